// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fair two-requester arbiter onto a shared memory port with wait-state timeout
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          grant_sel,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t r_state;
  logic r_last_gnt;
  logic [7:0] r_wait;
  logic w_if_el, w_dm_el, w_pick_d, w_busy, w_tmo, w_done;
  logic [DW-1:0] w_rdata;
  assign w_if_el  = if_req & ~if_ack;
  assign w_dm_el  = dm_req & ~dm_ack;
  assign w_pick_d = w_dm_el & (~w_if_el | ~r_last_gnt);
  assign w_busy   = r_state != IDLE;
  assign w_tmo    = w_busy & ~mem_ready & (r_wait == 8'(TIMEOUT - 1));
  assign w_done   = w_busy & (mem_ready | w_tmo);
  assign w_rdata  = mem_ready ? mem_rdata : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b0;
      r_wait     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      err        <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      grant_sel  <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      err    <= 1'b0;
      if (!w_busy) begin
        if (w_if_el | w_dm_el) begin
          r_state   <= w_pick_d ? BUSY_D : BUSY_I;
          mem_req   <= 1'b1;
          mem_we    <= w_pick_d & dm_we;
          mem_addr  <= w_pick_d ? dm_addr : if_addr;
          mem_wdata <= w_pick_d ? dm_wdata : '0;
          grant_sel <= w_pick_d;
          r_wait    <= '0;
        end
      end else if (w_done) begin
        r_state    <= IDLE;
        mem_req    <= 1'b0;
        r_last_gnt <= r_state == BUSY_D;
        err        <= w_tmo;
        if (r_state == BUSY_D) begin
          dm_ack   <= 1'b1;
          dm_rdata <= w_rdata;
        end else begin
          if_ack   <= 1'b1;
          if_rdata <= w_rdata;
        end
      end else begin
        r_wait <= r_wait + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector and sequence checks for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 0, rst_n = 0;
  logic if_req = 0, dm_req = 0, dm_we = 0, mem_ready = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic if_ack, dm_ack, mem_req, mem_we, grant_sel, err;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant_sel(grant_sel), .err(err)
  );
  typedef struct {
    logic if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic rdy;
    logic [31:0] rdata;
    logic e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic e_gsel, e_iack, e_dack, e_err;
    logic [31:0] e_irdata, e_drdata;
  } vec_t;
  vec_t v[8];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n, acks;
    logic g[6];
    v[0] = '{1,1,1,32'h300,32'h2000,32'hDEADBEEF,0,0,          1,1,32'h2000,32'hDEADBEEF,1,0,0,0,0,0};
    v[1] = '{1,1,1,32'h300,32'h2000,32'hDEADBEEF,1,32'h11111111, 0,0,0,0,1,0,1,0,0,32'h11111111};
    v[2] = '{1,0,0,32'h300,0,0,0,0,                            1,0,32'h300,0,0,0,0,0,0,32'h11111111};
    v[3] = '{1,0,0,32'h300,0,0,1,32'h22222222,                 0,0,0,0,0,1,0,0,32'h22222222,32'h11111111};
    v[4] = '{0,0,0,0,0,0,1,32'hFFFFFFFF,                       0,0,0,0,0,0,0,0,32'h22222222,32'h11111111};
    v[5] = '{1,0,0,32'h100,0,0,0,0,                            1,0,32'h100,0,0,0,0,0,32'h22222222,32'h11111111};
    v[6] = '{1,0,0,32'h100,0,0,1,32'h00500093,                 0,0,0,0,0,1,0,0,32'h00500093,32'h11111111};
    v[7] = '{0,0,0,0,0,0,0,0,                                  0,0,0,0,0,0,0,0,32'h00500093,32'h11111111};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_acks", {if_ack, dm_ack, err, grant_sel, mem_we}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", if_rdata | dm_rdata | mem_wdata, 0);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      if_req = v[i].if_req; dm_req = v[i].dm_req; dm_we = v[i].dm_we;
      if_addr = v[i].if_addr; dm_addr = v[i].dm_addr; dm_wdata = v[i].dm_wdata;
      mem_ready = v[i].rdy; mem_rdata = v[i].rdata;
      tick();
      chk($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(v[i].e_req));
      if (v[i].e_req) begin
        chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(v[i].e_we));
        chk($sformatf("v%0d_mem_addr", i), mem_addr, v[i].e_addr);
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, v[i].e_wdata);
      end
      chk($sformatf("v%0d_grant_sel", i), 32'(grant_sel), 32'(v[i].e_gsel));
      chk($sformatf("v%0d_if_ack", i), 32'(if_ack), 32'(v[i].e_iack));
      chk($sformatf("v%0d_dm_ack", i), 32'(dm_ack), 32'(v[i].e_dack));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(v[i].e_err));
      chk($sformatf("v%0d_if_rdata", i), if_rdata, v[i].e_irdata);
      chk($sformatf("v%0d_dm_rdata", i), dm_rdata, v[i].e_drdata);
    end
    // fairness: both requesters held continuously, zero-wait memory
    if_req = 1; dm_req = 1; dm_we = 0; if_addr = 32'h400; dm_addr = 32'h800; mem_ready = 0;
    n = 0; acks = 0;
    for (int c = 0; c < 40 && acks < 6; c++) begin
      tick();
      if (mem_req) begin
        if (n < 6) g[n] = grant_sel;
        n++;
      end
      if (if_ack | dm_ack) acks++;
      mem_ready = mem_req;
      mem_rdata = 32'hA0 + 32'(n);
    end
    if_req = 0; dm_req = 0; mem_ready = 0;
    chk("fair_grants", 32'(n), 6);
    for (int i = 0; i < 6 && i < n; i++) chk($sformatf("fair_g%0d", i), 32'(g[i]), 32'(i % 2 == 0));
    tick();
    // wait states on a data write
    dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'hCAFEF00D; mem_ready = 0;
    tick();
    dm_addr = 0; dm_wdata = 0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("ws%0d_req", k), 32'(mem_req), 1);
      chk($sformatf("ws%0d_addr", k), mem_addr, 32'h40);
      chk($sformatf("ws%0d_wdata", k), mem_wdata, 32'hCAFEF00D);
      chk($sformatf("ws%0d_ack", k), 32'(dm_ack), 0);
      tick();
    end
    chk("ws_still_busy", 32'(mem_req), 1);
    mem_ready = 1; mem_rdata = 32'h5A5A0001;
    tick();
    chk("ws_ack", 32'(dm_ack), 1);
    chk("ws_err", 32'(err), 0);
    chk("ws_rdata", dm_rdata, 32'h5A5A0001);
    dm_req = 0; mem_ready = 0;
    tick();
    chk("ws_ack_pulse", 32'(dm_ack), 0);
    // timeout on a fetch
    if_req = 1; if_addr = 32'h500; mem_rdata = 32'h12345678; mem_ready = 0;
    n = 0; acks = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (mem_req) n++;
      if (if_ack) begin
        acks = 1;
        break;
      end
    end
    chk("to_ack_seen", 32'(acks), 1);
    chk("to_busy_cycles", 32'(n), 16);
    chk("to_err", 32'(err), 1);
    chk("to_mem_req", 32'(mem_req), 0);
    chk("to_rdata", if_rdata, 0);
    if_req = 0;
    tick();
    chk("to_err_pulse", 32'(err), 0);
    chk("to_ack_pulse", 32'(if_ack), 0);
    // reset mid BUSY_D
    dm_req = 1; dm_we = 0; dm_addr = 32'h80;
    tick();
    chk("rb_busy", 32'(mem_req), 1);
    #3 rst_n = 0;
    #1;
    chk("rb_async_req", 32'(mem_req), 0);
    chk("rb_async_gsel", 32'(grant_sel), 0);
    tick();
    chk("rb_no_ack", 32'(dm_ack), 0);
    rst_n = 1;
    tick();
    chk("rb_regrant_req", 32'(mem_req), 1);
    chk("rb_regrant_gsel", 32'(grant_sel), 1);
    chk("rb_regrant_addr", mem_addr, 32'h80);
    chk("rb_regrant_ack", 32'(dm_ack), 0);
    mem_ready = 1; mem_rdata = 32'h77;
    tick();
    chk("rb_final_ack", 32'(dm_ack), 1);
    chk("rb_final_rdata", dm_rdata, 32'h77);
    dm_req = 0; mem_ready = 0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be:
- AW, default 32, address width.
- DW, default 32, data width.
- TIMEOUT, default 16, maximum BUSY cycles waiting for mem_ready (range 2..255).

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, level, held until if_ack.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  fetch read data.
- if_ack  out  1  fetch completion pulse.
- dm_req  in  1  data request, level, held until dm_ack.
- dm_we  in  1  data write enable.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  data write data.
- dm_rdata  out  DW  data read data.
- dm_ack  out  1  data completion pulse.
- mem_req  out  1  shared-port access strobe.
- mem_we  out  1  shared-port write enable.
- mem_addr  out  AW  shared-port address.
- mem_wdata  out  DW  shared-port write data.
- mem_rdata  in  DW  shared-port read data, valid with mem_ready.
- mem_ready  in  1  shared-port completion.
- grant_sel  out  1  address/data mux select, 0=fetch, 1=data.
- err  out  1  timeout pulse, coincident with the aborted ack.

Function
REQ-003 FSM SHALL have states IDLE, BUSY_I, BUSY_D.
REQ-004 In IDLE with exactly one eligible request, the FSM SHALL move to BUSY_I (fetch) or BUSY_D (data) on the next edge.
REQ-005 A request SHALL be eligible only if its own ack is low in that cycle.
REQ-006 In IDLE with both requests eligible, the grant SHALL go to the requester not granted last (register last_gnt).
REQ-007 last_gnt SHALL reset to fetch, so data wins the first contention.
REQ-008 On the grant edge, mem_we, mem_addr and mem_wdata SHALL be registered from the winner. For fetch: mem_we=0, mem_wdata=0.
REQ-009 These registered values SHALL stay stable for the whole BUSY state.
REQ-010 mem_req SHALL be high exactly while state is BUSY_I or BUSY_D.
REQ-011 grant_sel SHALL be 1 in BUSY_D and hold its last value in IDLE.
REQ-012 In BUSY_x with mem_ready=1, the FSM SHALL return to IDLE on the next edge and update last_gnt.
REQ-013 On that same edge, mem_rdata SHALL be registered into x_rdata (writes also capture mem_rdata) and x_ack SHALL be high for exactly one cycle.
REQ-014 Minimum latency from req (seen in IDLE) to ack SHALL be 2 cycles, with zero-wait memory.
REQ-015 A 8-bit wait counter SHALL clear on grant and increment each BUSY cycle with mem_ready=0.
REQ-016 When the wait counter reaches TIMEOUT-1 with mem_ready=0, the FSM SHALL return to IDLE, pulse x_ack and err for one cycle, and load x_rdata=0.
REQ-017 mem_ready in IDLE SHALL be ignored.
REQ-018 if_rdata and dm_rdata SHALL hold their values until the next ack of the same requester.
REQ-019 Requests arriving during BUSY SHALL wait, with no loss, and be arbitrated in the first eligible IDLE cycle.
REQ-020 Back-to-back grants SHALL require one IDLE cycle between accesses.
REQ-021 A requester dropping req while BUSY on its behalf SHALL NOT abort the access; its ack SHALL still be issued.

Reset
REQ-022 With rst_n=0, immediately and asynchronously: state=IDLE, all of the following =0:
- mem_req, mem_we, mem_addr, mem_wdata
- if_ack, dm_ack, err
- if_rdata, dm_rdata
- grant_sel, wait counter
and last_gnt=fetch.
REQ-023 Reset asserted mid-BUSY SHALL abandon the access with no ack issued.
REQ-024 Reset SHALL be released synchronously to clk by the system; the first grant is possible on the first edge after release.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Lone fetch: if_addr=0x100, mem_ready=1 with mem_rdata=0x00500093 in the first BUSY cycle -> mem_req 1 cycle, if_ack at cycle 2, if_rdata=0x00500093, err=0.
- Contention after reset: if_req and dm_req together, dm_we=1, dm_addr=0x2000, dm_wdata=0xDEADBEEF -> data served first (mem_we=1, grant_sel=1), then one IDLE cycle, then fetch served.
- Fairness: both requesters re-request continuously for 6 accesses -> grants alternate D,I,D,I,D,I; no requester waits more than one access.
- Wait states: memory holds mem_ready=0 for 5 BUSY cycles -> mem_addr and mem_wdata stable throughout, ack 1 cycle after mem_ready, no err.
- Timeout: mem_ready held 0 with TIMEOUT=16 -> FSM leaves BUSY after 16 cycles, ack and err pulse together, rdata=0.
- Reset mid-BUSY_D: rst_n low for 1 cycle -> mem_req=0 immediately, no dm_ack; a held dm_req is regranted after release.
